image_readout: RTL and testbench
================================

// Module: image_readout
// PURPOSE
//  Read-side counterpart of the 8x8 binary image register: steps through the stored 64-bit image one row at a time.
//  Presents the selected row on 8 LEDs with its row index.
//  Stepping is manual (one row per debounced btnNext press) or automatic (fixed dwell per row).
//  Sits between the image store and the board LEDs/7-seg; the image input is treated as quasi-static.
// PARAMETERS
//  CLK_HZ          100_000_000  system clock frequency, documentation/derivation only
//  DWELL_CYCLES    50_000_000   clocks each row is shown in AUTO mode (>=2)
//  DEBOUNCE_CYCLES 1_000_000    clocks a button level must be stable to be accepted (DEBOUNCE_EN only)
// PORTS
//  clk        in   1   system clock, rising edge
//  btnReset   in   1   reset, asynchronous, active-high
//  btnNext    in   1   raw push-button, advance one row (MANUAL mode)
//  btnAuto    in   1   raw push-button, toggle MANUAL/AUTO
//  img        in   64  image; row r = img[8*r+7 : 8*r]
//  led        out  8   currently selected row, registered
//  row        out  3   current row index
//  auto_on    out  1   1 while in AUTO
//  frame_done out  1   one-cycle pulse when row wraps 7->0
// BEHAVIOUR
//  - Reset: row=0, led=0, auto_on=0, frame_done=0, dwell counter=0, state=MANUAL, button sync/edge regs cleared.
//  - First clock after reset release: led=img[7:0].
//  - Buttons: two-flop synchroniser, optional debounce, then rising-edge detect.
//    Result is a one-cycle strobe per press; holding a button yields exactly one strobe.
//  - led <= img[8*row +: 8] every cycle, so led lags row/img changes by exactly 1 clk.
//  - FSM states:
//    - MANUAL: next strobe -> row+1; auto strobe -> AUTO, dwell counter cleared, row kept.
//    - AUTO: dwell counter counts 0..DWELL_CYCLES-1; at terminal count, row+1 and counter->0.
//      auto strobe -> MANUAL, row kept. next strobe is ignored.
//  - Same-cycle next and auto strobes: toggle wins, step discarded.
//  - Row arithmetic is 3-bit modulo 8: 7+1 -> 0, and frame_done=1 for that cycle only.
//  - img changing mid-display: led shows the new row value one clk later; row is unaffected.
//  - Reset mid-dwell or mid-press: everything returns to reset values immediately.
//    A button still held at release produces no strobe (edge regs reset to 0 and need the synced level to rise again).
// CONFIGURATION
//  DEBOUNCE_EN defined:
//    - each button passes through a stability counter.
//    - Filtered level changes only after DEBOUNCE_CYCLES consecutive identical synced samples.
//  DEBOUNCE_EN undefined:
//    - synchroniser + edge detect only.
//    - Strobe appears 3 clk after the raw rising edge; DEBOUNCE_CYCLES unused.
// STRUCTURE
//  - Shared package image_pkg:
//    - IMG_ROWS=8, ROW_W=8, IMG_W=64
//    - row index typedef (3-bit)
//    - mode enum {MODE_MANUAL, MODE_AUTO}
//    The same package is reused by the image writer.
//  - Sub-module btn_conditioner (sync + optional debounce + rising-edge strobe).
//    Instantiated twice: btnNext and btnAuto.
//  - Top holds FSM, dwell counter, row counter, LED mux register.
// TESTING (bench: DWELL_CYCLES=4, DEBOUNCE_CYCLES=3)
//  1. Reset, img=64'h8040_2010_0804_0201 -> led=8'h01, row=0 after 1 clk.
//     8 next presses -> led 02,04,...,80 then 01; frame_done pulses once at 7->0.
//  2. Hold btnNext high 50 clk -> row advances exactly once.
//     With DEBOUNCE_EN: a 2-clk glitch yields no advance.
//  3. auto press -> auto_on=1; row increments every 4 clk.
//     next presses ignored; second auto press -> auto_on=0, row frozen.
//  4. next and auto strobes in the same cycle from MANUAL, row=3 -> AUTO, row stays 3.
//  5. AUTO at row=5, mid-dwell: assert btnReset async between clk edges -> row=0, led=0, auto_on=0 immediately.
//     btnAuto held through release -> no strobe.
//  6. Change img row 2 from 8'h04 to 8'hAA while row=2 -> led=8'hAA on the next clk, row unchanged.

Source files
------------

// File: rtl/image_pkg.sv
// Shared definitions for the 8x8 binary image store and its readout path.
// Used by both the image writer and image_readout.
package image_pkg;

  localparam int IMG_ROWS = 8;
  localparam int ROW_W    = 8;
  localparam int IMG_W    = IMG_ROWS * ROW_W;

  typedef logic [2:0] row_t;

  typedef enum logic {
    MODE_MANUAL,
    MODE_AUTO
  } mode_t;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchroniser, optional stability filter
// (enabled by `define DEBOUNCE_EN), and a one-cycle rising-edge strobe.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic btnReset,
  input  logic btn,
  output logic strobe
);

  logic sync_p0, sync_p1;
  logic vld_p0, vld_p1;
  logic lvl;
  logic prev_p2;
  logic armed;

  // Stage 0/1: metastability synchroniser; vld marks when sync_p1 holds a real sample
  always_ff @(posedge clk or posedge btnReset) begin
    if (btnReset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] stab_cnt;
  logic             flt;

  // Filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge btnReset) begin
    if (btnReset) begin
      stab_cnt <= '0;
      flt      <= 1'b0;
    end else if (sync_p1 == flt) begin
      stab_cnt <= '0;
    end else if (stab_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stab_cnt <= '0;
      flt      <= sync_p1;
    end else begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign lvl = flt;
`else
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cfg
  end

  assign lvl = sync_p1;
`endif

  // Stage 2: edge detect. A button held across reset release must be seen
  // released (real low sample) before any strobe is allowed.
  always_ff @(posedge clk or posedge btnReset) begin
    if (btnReset) begin
      prev_p2 <= 1'b0;
      armed   <= 1'b0;
      strobe  <= 1'b0;
    end else begin
      prev_p2 <= lvl;
      armed   <= armed | (vld_p1 & ~lvl & ~sync_p1);
      strobe  <= lvl & ~prev_p2 & armed;
    end
  end

endmodule

// File: rtl/image_readout.sv
// Steps through a stored 8x8 image one row at a time, manually or on a timed dwell.
// Optional button debounce is selected with `define DEBOUNCE_EN.
module image_readout
  import image_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DWELL_CYCLES    = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             btnReset,
  input  logic             btnNext,
  input  logic             btnAuto,
  input  logic [IMG_W-1:0] img,
  output logic [ROW_W-1:0] led,
  output logic [2:0]       row,
  output logic             auto_on,
  output logic             frame_done
);

  localparam int DW_W = $clog2(DWELL_CYCLES);

  if (CLK_HZ < 1 || DWELL_CYCLES < 2) begin : g_bad_timing_cfg
  end

  logic next_stb, auto_stb;

  mode_t            state_q, state_nx;
  row_t             row_q, row_nx;
  logic [DW_W-1:0]  dwell_q, dwell_nx;
  logic             frame_nx;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk      (clk),
    .btnReset (btnReset),
    .btn      (btnNext),
    .strobe   (next_stb)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_auto (
    .clk      (clk),
    .btnReset (btnReset),
    .btn      (btnAuto),
    .strobe   (auto_stb)
  );

  always_ff @(posedge clk or posedge btnReset) begin
    if (btnReset) begin
      state_q    <= MODE_MANUAL;
      row_q      <= '0;
      dwell_q    <= '0;
      frame_done <= 1'b0;
      led        <= '0;
    end else begin
      state_q    <= state_nx;
      row_q      <= row_nx;
      dwell_q    <= dwell_nx;
      frame_done <= frame_nx;
      led        <= img[ROW_W*row_q +: ROW_W];
    end
  end

  // Mode toggle has priority over a step arriving in the same cycle
  always_comb begin
    state_nx = state_q;
    row_nx   = row_q;
    dwell_nx = dwell_q;
    case (state_q)
      MODE_MANUAL: begin
        if (auto_stb) begin
          state_nx = MODE_AUTO;
          dwell_nx = '0;
        end else if (next_stb) begin
          row_nx = row_q + 3'd1;
        end
      end
      MODE_AUTO: begin
        if (auto_stb) begin
          state_nx = MODE_MANUAL;
          dwell_nx = '0;
        end else if (dwell_q == DW_W'(DWELL_CYCLES - 1)) begin
          dwell_nx = '0;
          row_nx   = row_q + 3'd1;
        end else begin
          dwell_nx = dwell_q + 1'b1;
        end
      end
      default: state_nx = MODE_MANUAL;
    endcase
    frame_nx = (row_q == 3'd7) && (row_nx == 3'd0);
  end

  assign row     = row_q;
  assign auto_on = (state_q == MODE_AUTO);

endmodule

// File: tb/tb_image_readout.sv
// Randomised self-checking bench for image_readout against a sample-history model.
module tb_image_readout;

  localparam int DWELL = 4;
  localparam int DEB   = 3;
  localparam int HMAX  = 8192;

  logic        clk = 1'b0;
  logic        btnReset, btnNext, btnAuto;
  logic [63:0] img;
  logic [7:0]  led;
  logic [2:0]  row;
  logic        auto_on, frame_done;

  image_readout #(
    .CLK_HZ          (100_000_000),
    .DWELL_CYCLES    (DWELL),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .btnReset   (btnReset),
    .btnNext    (btnNext),
    .btnAuto    (btnAuto),
    .img        (img),
    .led        (led),
    .row        (row),
    .auto_on    (auto_on),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int frame_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: raw samples per edge since reset, derived settled level, arming
  bit rr[2][HMAX];
  bit ff[2][HMAX];
  bit ar[2][HMAX];
  int edge_n;
  int m_row, m_dwell;
  bit m_auto, m_frame;
  logic [7:0] m_led;

  function automatic bit rs(input int b, input int j);
    return (j < 1) ? 1'b0 : rr[b][j];
  endfunction

  function automatic bit fs(input int b, input int j);
    return (j < 0) ? 1'b0 : ff[b][j];
  endfunction

  task automatic model_reset();
    edge_n = 0;
    for (int b = 0; b < 2; b++) begin
      rr[b][0] = 1'b0;
      ff[b][0] = 1'b0;
      ar[b][0] = 1'b0;
    end
    m_row = 0; m_dwell = 0; m_auto = 1'b0; m_frame = 1'b0; m_led = 8'h00;
  endtask

  task automatic model_advance();
    m_row   = (m_row + 1) % 8;
    m_frame = (m_row == 0);
  endtask

  task automatic model_edge();
    bit stb[2];
    int k;
    if (edge_n >= HMAX - 1) begin
      check("model_history_overflow", 64'(edge_n), 64'(HMAX - 1));
      return;
    end
    edge_n++;
    k = edge_n;
    rr[0][k] = btnNext;
    rr[1][k] = btnAuto;
    for (int b = 0; b < 2; b++) begin
`ifdef DEBOUNCE_EN
      bit all_diff;
      ff[b][k] = ff[b][k-1];
      all_diff = (k - DEB - 1 >= 1);
      for (int i = k - DEB - 1; i <= k - 2; i++)
        if (rs(b, i) == ff[b][k-1]) all_diff = 1'b0;
      if (all_diff) ff[b][k] = ~ff[b][k-1];
`else
      ff[b][k] = rs(b, k - 1);
`endif
      ar[b][k] = ar[b][k-1] | ((k >= 3) && !fs(b, k - 1) && !rs(b, k - 2));
      stb[b]   = (k >= 3) && fs(b, k - 2) && !fs(b, k - 3) && ar[b][k-2];
    end
    m_led   = img[8*m_row +: 8];
    m_frame = 1'b0;
    if (!m_auto) begin
      if (stb[1]) begin m_auto = 1'b1; m_dwell = 0; end
      else if (stb[0]) model_advance();
    end else begin
      if (stb[1]) m_auto = 1'b0;
      else if (m_dwell == DWELL - 1) begin m_dwell = 0; model_advance(); end
      else m_dwell++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!btnReset) model_edge();
    @(negedge clk);
    if (frame_done === 1'b1) frame_cnt++;
    check("row", 64'(row), 64'(m_row));
    check("led", 64'(led), 64'(m_led));
    check("auto_on", 64'(auto_on), 64'(m_auto));
    check("frame_done", 64'(frame_done), 64'(m_frame));
  endtask

  task automatic do_reset();
    btnReset = 1'b1;
    #1;
    model_reset();
    check("rst_row", 64'(row), 64'd0);
    check("rst_led", 64'(led), 64'd0);
    check("rst_auto_on", 64'(auto_on), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    tick();
    tick();
    btnReset = 1'b0;
  endtask

  task automatic press(input int b, input int hold, input int gap);
    if (b == 0) btnNext = 1'b1; else btnAuto = 1'b1;
    repeat (hold) tick();
    if (b == 0) btnNext = 1'b0; else btnAuto = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] prev_row;
    int chg, guard, run_n, run_a;

    btnReset = 1'b1; btnNext = 1'b0; btnAuto = 1'b0;
    img = 64'h8040_2010_0804_0201;
    do_reset();

    // 1: first row after release, then eight manual steps around the frame
    tick();
    check("t1_led_first", 64'(led), 64'h01);
    check("t1_row_first", 64'(row), 64'd0);
    frame_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_led;
      exp_led = 8'h01 << ((i + 1) % 8);
      press(0, 6, 6);
      check("t1_led_step", 64'(led), 64'(exp_led));
    end
    check("t1_row_wrap", 64'(row), 64'd0);
    check("t1_frame_pulses", 64'(frame_cnt), 64'd1);

    // 2: long hold gives a single step; short glitch is filtered when debounced
    press(0, 50, 8);
    check("t2_hold_once", 64'(row), 64'd1);
`ifdef DEBOUNCE_EN
    press(0, 2, 8);
    check("t2_glitch", 64'(row), 64'd1);
`endif

    // 3: AUTO stepping cadence, next ignored, toggle back freezes row
    press(1, 6, 4);
    check("t3_auto_on", 64'(auto_on), 64'd1);
    chg = 0;
    prev_row = row;
    for (int j = 0; j < 16; j++) begin
      btnNext = (j % 8) < 4;
      tick();
      if (row != prev_row) chg++;
      prev_row = row;
    end
    btnNext = 1'b0;
    check("t3_auto_rate", 64'(chg), 64'd4);
    press(1, 6, 4);
    check("t3_auto_off", 64'(auto_on), 64'd0);
    chg = 0;
    prev_row = row;
    repeat (12) begin
      tick();
      if (row != prev_row) chg++;
      prev_row = row;
    end
    check("t3_frozen", 64'(chg), 64'd0);

    // 4: simultaneous next+auto at row 3 -> AUTO with row kept
    guard = 0;
    while (m_row != 3 && guard < 10) begin press(0, 6, 6); guard++; end
    check("t4_row3", 64'(row), 64'd3);
    btnNext = 1'b1; btnAuto = 1'b1;
    guard = 0;
    while (!m_auto && guard < 12) begin tick(); guard++; end
    check("t4_auto_on", 64'(auto_on), 64'd1);
    check("t4_row_kept", 64'(row), 64'd3);
    btnNext = 1'b0; btnAuto = 1'b0;

    // 5: async reset mid-dwell at row 5 with btnAuto held through release
    guard = 0;
    while (!(m_auto && m_row == 5 && m_dwell == 1) && guard < 100) begin tick(); guard++; end
    check("t5_reach_row5", 64'(row), 64'd5);
    btnAuto = 1'b1;
    #3;
    do_reset();
    repeat (20) tick();
    check("t5_no_strobe", 64'(auto_on), 64'd0);
    btnAuto = 1'b0;
    repeat (8) tick();

    // 6: image update while displayed row is 2
    guard = 0;
    while (m_row != 2 && guard < 10) begin press(0, 6, 6); guard++; end
    img[23:16] = 8'hAA;
    tick();
    check("t6_led_new", 64'(led), 64'hAA);
    check("t6_row_kept", 64'(row), 64'd2);

    // Random phase: button levels with random run lengths, image edits, rare resets
    run_n = 0; run_a = 0;
    for (int c = 0; c < 800; c++) begin
      if (run_n == 0) begin btnNext = $urandom_range(0, 1); run_n = $urandom_range(1, 12); end
      if (run_a == 0) begin btnAuto = ($urandom_range(0, 3) == 0); run_a = $urandom_range(1, 16); end
      run_n--; run_a--;
      if ($urandom_range(0, 15) == 0) img[8*$urandom_range(0, 7) +: 8] = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin #3; do_reset(); end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
